fetch_queue_unit: RTL and testbench

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

---
 rtl/fetch_queue_unit.sv | 74 +++++++
 tb/tb_fetch_queue_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: sequential instruction fetch from a word memory into a circular queue with redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects set a sticky error and halt fetch instead of being aligned.
module fetch_queue_unit #(
  parameter int XLEN = 64,
  parameter int IMEM_WORDS = 256,
  parameter int FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                          Clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [31:0]                   out_instr,
  output logic [$clog2(FQ_DEPTH):0]     fq_count,
  output logic                          misalign_err
);
  localparam int AW = $clog2(IMEM_WORDS);
  localparam int QW = $clog2(FQ_DEPTH);
  logic [31:0] mem [IMEM_WORDS];
  logic [XLEN-1:0] q_pc [FQ_DEPTH];
  logic [31:0] q_instr [FQ_DEPTH];
  logic [XLEN-1:0] fpc, target;
  logic [QW-1:0] rd_ptr, wr_ptr;
  logic pop, push, halt;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign target = redirect_pc;
  assign halt = misalign_err;
  always_ff @(posedge Clk or posedge reset)
    if (reset) misalign_err <= 1'b0;
    else if (redirect_valid) misalign_err <= |redirect_pc[1:0];
`else
  assign target = redirect_pc & ~XLEN'(3);
  assign halt = 1'b0;
  assign misalign_err = 1'b0;
`endif
  assign out_valid = fq_count != '0;
  assign pop = out_valid & out_ready & ~redirect_valid;
  assign push = ~redirect_valid & ~halt & ((fq_count < (QW+1)'(FQ_DEPTH)) | pop);
  // Gate the head with out_valid so an empty or reset queue presents zeros.
  assign out_pc = out_valid ? q_pc[rd_ptr] : '0;
  assign out_instr = out_valid ? q_instr[rd_ptr] : '0;
  always_ff @(posedge Clk)
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  always_ff @(posedge Clk)
    if (push) begin
      q_pc[wr_ptr] <= fpc;
      q_instr[wr_ptr] <= mem[fpc[2 +: AW]];
    end
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      fpc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fq_count <= '0;
    end else if (redirect_valid) begin
      fpc <= target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fq_count <= '0;
    end else begin
      if (push) begin
        fpc <= fpc + XLEN'(4);
        wr_ptr <= wr_ptr + QW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + QW'(1);
      fq_count <= fq_count + {{QW{1'b0}}, push} - {{QW{1'b0}}, pop};
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: scoreboard bench for fetch_queue_unit at default parameters.
module tb_fetch_queue_unit;
  logic Clk = 0, reset = 1, redirect_valid = 0, imem_we = 0, out_ready = 0;
  logic [63:0] redirect_pc = '0;
  logic [7:0] imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic out_valid, misalign_err;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0] fq_count;
  typedef struct {logic [63:0] pc; logic [31:0] instr;} ent_t;
  ent_t sb[$];
  logic [31:0] mem_m [256];
  int n_cmp = 0, n_bad = 0, n_pop = 0;

  fetch_queue_unit dut (.Clk(Clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .fq_count(fq_count), .misalign_err(misalign_err));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_load(input logic [63:0] start);
    sb.delete();
    for (int i = 0; i < 40; i++) begin
      logic [63:0] p;
      p = start + 64'(4 * i);
      sb.push_back('{p, mem_m[p[9:2]]});
    end
  endtask

  // Handshake is judged at the negedge, then inputs change 1 after the posedge.
  task automatic step();
    @(negedge Clk);
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        ent_t e;
        e = sb.pop_front();
        n_pop++;
        chk("hs_pc", out_pc, e.pc);
        chk("hs_instr", {32'b0, out_instr}, {32'b0, e.instr});
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic redir(input logic [63:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
    step();
    redirect_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = {16'hBEEF, 8'(i), 8'(~i)};
    for (int i = 0; i < 256; i++) begin
      imem_we = 1; imem_waddr = 8'(i); imem_wdata = mem_m[i];
      step();
    end
    imem_we = 0;
    chk("rst_valid", {63'b0, out_valid}, 0);
    chk("rst_count", {61'b0, fq_count}, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", {32'b0, out_instr}, 0);
    chk("rst_mis", {63'b0, misalign_err}, 0);
    // streaming from reset
    sb_load(0); out_ready = 1; reset = 0;
    step();
    chk("first_valid", {63'b0, out_valid}, 1);
    chk("first_pc", out_pc, 0);
    for (int i = 0; i < 12; i++) step();
    chk("stream_count", {61'b0, fq_count}, 1);
    // stall fills the queue
    reset = 1; out_ready = 0; step();
    sb_load(0); reset = 0;
    for (int i = 0; i < 10; i++) step();
    chk("full_count", {61'b0, fq_count}, 4);
    chk("full_head", out_pc, 0);
    chk("full_instr", {32'b0, out_instr}, {32'b0, mem_m[0]});
    chk("full_fpc", dut.fpc, 64'h10);
    out_ready = 1;
    step();
    chk("full_pushpop", {61'b0, fq_count}, 4);
    for (int i = 0; i < 5; i++) step();
    // redirect with 3 entries queued
    out_ready = 0; sb.delete();
    redir(0);
    for (int i = 0; i < 3; i++) step();
    chk("three_count", {61'b0, fq_count}, 3);
    sb_load(64'h14); out_ready = 1;
    redir(64'h14);
    chk("redir_valid", {63'b0, out_valid}, 0);
    chk("redir_count", {61'b0, fq_count}, 0);
    step();
    chk("redir_pc", out_pc, 64'h14);
    for (int i = 0; i < 4; i++) step();
    // memory wrap
    sb_load(64'h3F8);
    redir(64'h3F8);
    for (int i = 0; i < 6; i++) step();
    // misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
    sb.delete();
    redir(64'h22);
    chk("mis_set", {63'b0, misalign_err}, 1);
    for (int i = 0; i < 5; i++) step();
    chk("mis_nopush", {61'b0, fq_count}, 0);
    chk("mis_fpc", dut.fpc, 64'h22);
    sb_load(64'h40);
    redir(64'h40);
    chk("mis_clear", {63'b0, misalign_err}, 0);
    for (int i = 0; i < 5; i++) step();
`else
    sb_load(64'h20);
    redir(64'h22);
    chk("mis_tied", {63'b0, misalign_err}, 0);
    step();
    chk("mis_align_pc", out_pc, 64'h20);
    for (int i = 0; i < 4; i++) step();
`endif
    // reset mid-stream with queue full
    out_ready = 0;
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst_count", {61'b0, fq_count}, 4);
    reset = 1;
    #1;
    chk("arst_valid", {63'b0, out_valid}, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_instr", {32'b0, out_instr}, 0);
    chk("arst_count", {61'b0, fq_count}, 0);
    step();
    sb_load(0); reset = 0; out_ready = 1;
    for (int i = 0; i < 6; i++) step();
    chk("pops_seen", {63'b0, n_pop >= 30}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
